// File: rtl/alu_result_drain_pkg.sv
// Shared ALU opcode set, drain destinations and drain state encoding.
// Used by the ALU, the control unit and the Z-register drain stage.
package alu_result_drain_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHRA = 5'b00110;
  localparam logic [4:0] OP_SHL  = 5'b00111;
  localparam logic [4:0] OP_ROR  = 5'b01000;
  localparam logic [4:0] OP_ROL  = 5'b01001;
  localparam logic [4:0] OP_AND  = 5'b01010;
  localparam logic [4:0] OP_OR   = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  localparam logic [1:0] DEST_GPR = 2'b00;
  localparam logic [1:0] DEST_LO  = 2'b01;
  localparam logic [1:0] DEST_HI  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_SEND_LO = 2'b01,
    ST_SEND_HI = 2'b10
  } drain_state_e;

  function automatic logic is_two_word(
    input logic [4:0] op
  );
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_result_flag_gen.sv
// Zero/negative detection on the captured ALU result.
// Width of the test follows single- vs two-word ops.
module alu_result_flag_gen #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2*DATA_WIDTH-1:0] result,
  input  logic                    two_word,
  output logic                    flag_zero,
  output logic                    flag_neg
);

  always_comb begin
    flag_zero = (result[DATA_WIDTH-1:0] == '0);
    flag_neg  = result[DATA_WIDTH-1];
    if (two_word) begin
      flag_zero = (result == '0);
      flag_neg  = result[2*DATA_WIDTH-1];
    end
  end

endmodule

// File: rtl/alu_result_drain.sv
// Z register stage: captures the ALU result, drains it as 1-2 words.
// Optional flag outputs under ALU_RESULT_FLAGS_EN.
module alu_result_drain
  import alu_result_drain_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clock,
  input  logic                    clear,
  input  logic                    z_in,
  input  logic [4:0]              op,
  input  logic [2*DATA_WIDTH-1:0] result,
  output logic                    busy,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [1:0]              out_dest,
  output logic                    done,
`ifdef ALU_RESULT_FLAGS_EN
  output logic                    flag_zero,
  output logic                    flag_neg,
`endif
  output logic                    overrun
);

  drain_state_e state;
  drain_state_e state_d;

  // out_data already holds the low half of Z, so only the high half is kept.
  logic [DATA_WIDTH-1:0] z_hi;
  logic                  two_word;
  logic                  new_two;
  logic                  hs;
  logic                  last_hs;
  logic                  capture;
  logic                  load_hi;
  logic                  overrun_set;

  assign out_valid = (state != ST_IDLE);
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clock) begin
    if (clear) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    capture = 1'b0;
    load_hi = 1'b0;
    last_hs = 1'b0;
    hs      = out_valid && out_ready;
    new_two = is_two_word(op);
    unique case (state)
      ST_IDLE: begin
        if (z_in) begin
          capture = 1'b1;
          state_d = ST_SEND_LO;
        end
      end
      ST_SEND_LO: begin
        if (hs) begin
          if (two_word) begin
            load_hi = 1'b1;
            state_d = ST_SEND_HI;
          end else begin
            last_hs = 1'b1;
          end
        end
      end
      ST_SEND_HI: begin
        if (hs) begin
          last_hs = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A new result may chain straight onto the final handshake.
    if (last_hs) begin
      capture = z_in;
      state_d = z_in ? ST_SEND_LO : ST_IDLE;
    end
    overrun_set = z_in && busy && !last_hs;
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      z_hi     <= '0;
      two_word <= 1'b0;
      out_data <= '0;
      out_dest <= DEST_GPR;
      done     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      done <= last_hs;
      if (overrun_set) begin
        overrun <= 1'b1;
      end
      if (capture) begin
        z_hi     <= result[2*DATA_WIDTH-1:DATA_WIDTH];
        two_word <= new_two;
        out_data <= result[DATA_WIDTH-1:0];
        out_dest <= new_two ? DEST_LO : DEST_GPR;
      end else if (load_hi) begin
        out_data <= z_hi;
        out_dest <= DEST_HI;
      end
    end
  end

`ifdef ALU_RESULT_FLAGS_EN
  logic fz_d;
  logic fn_d;

  alu_result_flag_gen #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_flag_gen (
    .result   (result),
    .two_word (new_two),
    .flag_zero(fz_d),
    .flag_neg (fn_d)
  );

  always_ff @(posedge clock) begin
    if (clear) begin
      flag_zero <= 1'b0;
      flag_neg  <= 1'b0;
    end else if (capture) begin
      flag_zero <= fz_d;
      flag_neg  <= fn_d;
    end
  end
`endif

endmodule

// File: tb/tb_alu_result_drain.sv
// Directed bench for alu_result_drain with a word-queue reference model.
// Compile with ALU_RESULT_FLAGS_EN to also cover the flag outputs.
module tb_alu_result_drain;

  logic        clock;
  logic        clear;
  logic        z_in;
  logic [4:0]  op;
  logic [63:0] result;
  logic        busy;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  out_dest;
  logic        done;
  logic        overrun;
`ifdef ALU_RESULT_FLAGS_EN
  logic        flag_zero;
  logic        flag_neg;
`endif

  alu_result_drain #(
    .DATA_WIDTH(32)
  ) dut (
    .clock    (clock),
    .clear    (clear),
    .z_in     (z_in),
    .op       (op),
    .result   (result),
    .busy     (busy),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_dest (out_dest),
    .done     (done),
`ifdef ALU_RESULT_FLAGS_EN
    .flag_zero(flag_zero),
    .flag_neg (flag_neg),
`endif
    .overrun  (overrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h",
               name, $time, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] data;
    logic [1:0]  dest;
    bit          last;
  } word_t;

  word_t       q[$];
  logic [31:0] m_data;
  logic [1:0]  m_dest;
  logic        m_done;
  logic        m_over;
  logic        m_fz;
  logic        m_fn;
  bit          m_hs;
  bit          m_fin;
  bit          m_two;

  // Reference: each capture enqueues the words it must produce.
  always @(posedge clock) begin
    if (clear) begin
      q.delete();
      m_data = '0;
      m_dest = 2'b00;
      m_done = 1'b0;
      m_over = 1'b0;
      m_fz   = 1'b0;
      m_fn   = 1'b0;
    end else begin
      m_hs   = (q.size() > 0) && out_ready;
      m_fin  = m_hs && q[0].last;
      m_done = m_fin;
      if (m_hs) void'(q.pop_front());
      if (z_in) begin
        if (q.size() == 0) begin
          m_two = (op == 5'b01111) || (op == 5'b10000);
          if (m_two) begin
            q.push_back('{result[31:0], 2'b01, 1'b0});
            q.push_back('{result[63:32], 2'b10, 1'b1});
            m_fz = (result == 64'd0);
            m_fn = result[63];
          end else begin
            q.push_back('{result[31:0], 2'b00, 1'b1});
            m_fz = (result[31:0] == 32'd0);
            m_fn = result[31];
          end
        end else begin
          m_over = 1'b1;
        end
      end
      if (q.size() > 0) begin
        m_data = q[0].data;
        m_dest = q[0].dest;
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
      chk("busy", 64'(busy), 64'(q.size() > 0));
      chk("out_data", 64'(out_data), 64'(m_data));
      chk("out_dest", 64'(out_dest), 64'(m_dest));
      chk("done", 64'(done), 64'(m_done));
      chk("overrun", 64'(overrun), 64'(m_over));
`ifdef ALU_RESULT_FLAGS_EN
      chk("flag_zero", 64'(flag_zero), 64'(m_fz));
      chk("flag_neg", 64'(flag_neg), 64'(m_fn));
`endif
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic load(input logic [4:0] o, input logic [63:0] r);
    z_in   = 1'b1;
    op     = o;
    result = r;
  endtask

  initial begin
    clear     = 1'b1;
    z_in      = 1'b0;
    op        = 5'd0;
    result    = 64'd0;
    out_ready = 1'b1;
    step();
    step();
    clear  = 1'b0;
    chk_en = 1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_over", 64'(overrun), 64'd0);

    // ADD, single word
    load(5'b00011, 64'h7);
    step();
    z_in = 1'b0;
    chk("add_valid", 64'(out_valid), 64'd1);
    chk("add_data", 64'(out_data), 64'h7);
    chk("add_dest", 64'(out_dest), 64'd0);
    step();
    chk("add_done", 64'(done), 64'd1);
    chk("add_busy", 64'(busy), 64'd0);
    step();
    chk("add_done_end", 64'(done), 64'd0);

    // MUL, two words back to back
    load(5'b01111, 64'hFFFF_FFFF_8000_0000);
    step();
    z_in = 1'b0;
    chk("mul_lo", 64'(out_data), 64'h8000_0000);
    chk("mul_lo_dest", 64'(out_dest), 64'd1);
`ifdef ALU_RESULT_FLAGS_EN
    chk("mul_neg", 64'(flag_neg), 64'd1);
    chk("mul_zero", 64'(flag_zero), 64'd0);
`endif
    step();
    chk("mul_hi", 64'(out_data), 64'hFFFF_FFFF);
    chk("mul_hi_dest", 64'(out_dest), 64'd2);
    chk("mul_no_done", 64'(done), 64'd0);
    step();
    chk("mul_done", 64'(done), 64'd1);
    step();

    // DIV with a 3-cycle stall in SEND_LO
    load(5'b10000, 64'h1234_5678_9ABC_DEF0);
    out_ready = 1'b0;
    step();
    z_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("div_stall_data", 64'(out_data), 64'h9ABC_DEF0);
      chk("div_stall_dest", 64'(out_dest), 64'd1);
      step();
    end
    out_ready = 1'b1;
    step();
    chk("div_hi", 64'(out_data), 64'h1234_5678);
    step();
    chk("div_done", 64'(done), 64'd1);
    step();
    step();

    // Overrun in SEND_HI, then a chained capture on the final handshake
    load(5'b01111, 64'hAAAA_AAAA_5555_5555);
    step();
    z_in = 1'b0;
    step();
    load(5'b00011, 64'h99);
    out_ready = 1'b0;
    step();
    z_in = 1'b0;
    chk("ovr_set", 64'(overrun), 64'd1);
    chk("ovr_hold", 64'(out_data), 64'hAAAA_AAAA);
    step();
    load(5'b00011, 64'h42);
    out_ready = 1'b1;
    step();
    z_in = 1'b0;
    chk("chain_done", 64'(done), 64'd1);
    chk("chain_valid", 64'(out_valid), 64'd1);
    chk("chain_data", 64'(out_data), 64'h42);
    chk("chain_dest", 64'(out_dest), 64'd0);
    step();
    step();

    // clear during SEND_HI
    load(5'b01111, 64'h0123_4567_89AB_CDEF);
    step();
    z_in = 1'b0;
    step();
    out_ready = 1'b0;
    clear     = 1'b1;
    step();
    clear     = 1'b0;
    out_ready = 1'b1;
    chk("clr_valid", 64'(out_valid), 64'd0);
    chk("clr_data", 64'(out_data), 64'd0);
    chk("clr_done", 64'(done), 64'd0);
    chk("clr_over", 64'(overrun), 64'd0);
    step();
    chk("clr_no_done", 64'(done), 64'd0);

    // SUB with zero result
    load(5'b00100, 64'h0);
    step();
    z_in = 1'b0;
    chk("sub_dest", 64'(out_dest), 64'd0);
`ifdef ALU_RESULT_FLAGS_EN
    chk("sub_zero", 64'(flag_zero), 64'd1);
    chk("sub_neg", 64'(flag_neg), 64'd0);
`endif
    step();
    // Illegal opcode is a single-word transfer
    load(5'b11111, 64'hDEAD_BEEF_0000_0001);
    step();
    z_in = 1'b0;
    chk("ill_dest", 64'(out_dest), 64'd0);
    step();
    chk("ill_done", 64'(done), 64'd1);
    step();
    step();

    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_result_drain.md
Name: alu_result_drain

Overview:
- Consumer end of the ALU result path; implements the Z register stage.
- Captures the 64-bit ALU result and its opcode on a Zin strobe.
- Drains the result onto the 32-bit datapath as one or two words over a valid/ready handshake, tagged with a destination: general register, LO or HI.
- MUL and DIV drain two words (LO then HI); every other op drains the low word only.

Parameters:
- DATA_WIDTH, 32, width of one datapath word; the captured result is 2*DATA_WIDTH.

Ports:
- clock      input   1                clock; all state updates on rising edge
- clear      input   1                reset, synchronous, active-high
- z_in       input   1                capture strobe for result/op
- op         input   5                ALU opcode accompanying result
- result     input   2*DATA_WIDTH     ALU result
- busy       output  1                high whenever the FSM is not IDLE
- out_valid  output  1                out_data/out_dest valid
- out_ready  input   1                downstream accepts the word this cycle
- out_data   output  DATA_WIDTH       word being drained
- out_dest   output  2                00 = general register (Rz), 01 = LO, 10 = HI; 11 never driven
- done       output  1                one-cycle pulse after the final word is accepted
- overrun    output  1                sticky; z_in arrived while busy and not accepted

Behaviour:
- Reset (clear high at a clock edge, including mid-drain): state IDLE, Z register = 0, out_valid = 0, out_data = 0, out_dest = 00, done = 0, overrun = 0, busy = 0. Any in-progress drain is abandoned with no done pulse.
- States: IDLE, SEND_LO, SEND_HI.
- IDLE:
  - If z_in = 1: latch result into Z, and latch two_word = (op == 5'b01111 MUL || op == 5'b10000 DIV). Go to SEND_LO.
  - Otherwise hold.
- Latency: out_valid rises the cycle after z_in is sampled.
- SEND_LO:
  - out_valid = 1; out_data = Z[DATA_WIDTH-1:0]; out_dest = 01 if two_word, else 00.
  - On handshake (out_valid && out_ready): go to SEND_HI if two_word, else finish.
- SEND_HI:
  - out_valid = 1; out_data = Z[2*DATA_WIDTH-1:DATA_WIDTH]; out_dest = 10.
  - On handshake: finish.
- Finish: done = 1 for exactly the following cycle. The next state is IDLE, unless z_in is high in the same cycle as the final handshake; then capture the new result and go directly to SEND_LO. The done pulse for the old transfer still fires, and out_valid stays high with the new word.
- Stall: while out_valid && !out_ready, out_data and out_dest hold stable; no timeout.
- z_in while busy, other than during the final handshake cycle: ignored; Z is unchanged; overrun is set and stays set until clear.
- Opcodes not listed above, including illegal ones, are treated as single-word.
- No arithmetic is performed; the result passes through bit-exact.
- out_data and out_dest are registered. When out_valid = 0 they hold their last values.

Optional Feature:
- Macro: ALU_RESULT_FLAGS_EN.
- Defined:
  - Adds outputs flag_zero (1) and flag_neg (1), registered at capture and held until the next capture; both reset to 0.
  - Single-word op: flag_zero = (result[DATA_WIDTH-1:0] == 0); flag_neg = result[DATA_WIDTH-1].
  - Two-word op: flag_zero = (result == 0); flag_neg = result[2*DATA_WIDTH-1].
- Undefined: the ports do not exist and there is no flag logic; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - ALU opcode constants (MUL = 5'b01111, DIV = 5'b10000, plus the rest of the ALU op set), shared with the ALU and the control unit.
  - Destination encodings DEST_GPR / DEST_LO / DEST_HI.
  - The drain state enum.
- One sub-module, alu_result_flag_gen: combinational zero/negative detection. Instantiated only under ALU_RESULT_FLAGS_EN.
- FSM and Z register stay in the top module.

Test Plan:
- ADD (op 00011), result 64'h0000_0000_0000_0007, out_ready held 1:
  - out_valid rises the next cycle with out_data 32'h7, out_dest 00.
  - One-word transfer; done pulses the cycle after; busy returns to 0.
- MUL (op 01111), result 64'hFFFF_FFFF_8000_0000, out_ready = 1: LO word 32'h8000_0000 with dest 01, then HI word 32'hFFFF_FFFF with dest 10 on consecutive cycles; single done pulse. With the macro defined: flag_neg = 1, flag_zero = 0.
- DIV with out_ready low for 3 cycles during SEND_LO: out_data and out_dest hold stable throughout; transfer completes once out_ready rises; no extra words.
- z_in pulsed in SEND_HI with out_ready low:
  - overrun sets and Z is unchanged.
  - Second z_in coincident with the final handshake: new result captured, out_valid stays high with the new LO word, done still pulses.
- clear asserted during SEND_HI of a MUL: next cycle all outputs are at reset values, no done pulse, overrun cleared.
- SUB (op 00100) with result 0, macro defined: flag_zero = 1, flag_neg = 0, out_dest 00.
